// File: rtl/pmu_norm.sv
// Parametrised Viterbi path-metric bank with threshold renormalisation and best-state report.
// Optional sticky metric-spread check enabled by defining PMU_SPREAD_CHK_EN.
module pmu_norm #(
  parameter int NUM_STATES  = 4,
  parameter int PM_W        = 8,
  parameter int START_STATE = 0,
  parameter int NORM_THRESH = 2**(PM_W-1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  input  logic                           init_i,
  input  logic [NUM_STATES*PM_W-1:0]     pm_new_i,
  output logic [NUM_STATES*PM_W-1:0]     pm_o,
  output logic                           valid_o,
  output logic [$clog2(NUM_STATES)-1:0]  best_state_o,
  output logic [PM_W-1:0]                best_pm_o,
  output logic                           norm_o,
  output logic [15:0]                    norm_cnt_o
`ifdef PMU_SPREAD_CHK_EN
  ,
  output logic                           spread_err_o
`endif
);

  localparam int ST_W  = $clog2(NUM_STATES);
  localparam int NODES = 2*NUM_STATES - 1;
  localparam logic [PM_W:0]   THRESH = (PM_W+1)'(NORM_THRESH);
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [NUM_STATES*PM_W-1:0] pm_reg;
  logic [NUM_STATES*PM_W-1:0] pm_next;
  logic [NUM_STATES*PM_W-1:0] init_pm;
  logic [ST_W-1:0]            best_state_reg;
  logic [PM_W-1:0]            best_pm_reg;
  logic                       valid_reg;
  logic                       norm_reg;
  logic [15:0]                norm_cnt_reg;

  logic [PM_W-1:0] tree_pm  [NODES];
  logic [ST_W-1:0] tree_idx [NODES];
  logic [PM_W-1:0] min_pm;
  logic [ST_W-1:0] min_idx;
  logic            norm_hit;
  logic [PM_W-1:0] sub_val;

  // Heap-ordered tree: leaves at NUM_STATES-1.., left child always covers lower indices,
  // so preferring the left operand on ties yields the lowest tied index.
  always_comb begin
    for (int k = 0; k < NUM_STATES; k++) begin
      tree_pm[NUM_STATES-1+k]  = pm_new_i[k*PM_W +: PM_W];
      tree_idx[NUM_STATES-1+k] = ST_W'(k);
    end
    for (int n = NUM_STATES-2; n >= 0; n--) begin
      if (tree_pm[2*n+2] < tree_pm[2*n+1]) begin
        tree_pm[n]  = tree_pm[2*n+2];
        tree_idx[n] = tree_idx[2*n+2];
      end else begin
        tree_pm[n]  = tree_pm[2*n+1];
        tree_idx[n] = tree_idx[2*n+1];
      end
    end
  end

  assign min_pm   = tree_pm[0];
  assign min_idx  = tree_idx[0];
  assign norm_hit = ({1'b0, min_pm} >= THRESH);
  assign sub_val  = norm_hit ? min_pm : '0;

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state
      assign pm_next[gi*PM_W +: PM_W] = pm_new_i[gi*PM_W +: PM_W] - sub_val;
      assign init_pm[gi*PM_W +: PM_W] = (gi == START_STATE) ? '0 : PM_MAX;
    end
  endgenerate

  // Frame-start reload has exactly the same effect as reset.
  always_ff @(posedge clk) begin
    if (rst || init_i) begin
      pm_reg         <= init_pm;
      best_state_reg <= ST_W'(START_STATE);
      best_pm_reg    <= '0;
      valid_reg      <= 1'b0;
      norm_reg       <= 1'b0;
      norm_cnt_reg   <= '0;
    end else if (valid_i) begin
      pm_reg         <= pm_next;
      best_state_reg <= min_idx;
      best_pm_reg    <= norm_hit ? '0 : min_pm;
      valid_reg      <= 1'b1;
      norm_reg       <= norm_hit;
      if (norm_hit && (norm_cnt_reg != 16'hFFFF))
        norm_cnt_reg <= norm_cnt_reg + 16'd1;
    end else begin
      valid_reg      <= 1'b0;
      norm_reg       <= 1'b0;
    end
  end

  assign pm_o         = pm_reg;
  assign valid_o      = valid_reg;
  assign best_state_o = best_state_reg;
  assign best_pm_o    = best_pm_reg;
  assign norm_o       = norm_reg;
  assign norm_cnt_o   = norm_cnt_reg;

`ifdef PMU_SPREAD_CHK_EN
  logic [PM_W-1:0] sp_min;
  logic [PM_W-1:0] sp_max;
  logic [PM_W-1:0] sp_cur;
  logic            sp_any;
  logic            spread_hit;
  logic            spread_err_reg;

  // All-ones marks an unreached state and is left out of the spread.
  always_comb begin
    sp_min = PM_MAX;
    sp_max = '0;
    sp_cur = '0;
    sp_any = 1'b0;
    for (int k = 0; k < NUM_STATES; k++) begin
      sp_cur = pm_new_i[k*PM_W +: PM_W];
      if (sp_cur != PM_MAX) begin
        sp_any = 1'b1;
        if (sp_cur < sp_min) sp_min = sp_cur;
        if (sp_cur > sp_max) sp_max = sp_cur;
      end
    end
  end

  assign spread_hit = sp_any && ({1'b0, sp_max - sp_min} >= THRESH);

  always_ff @(posedge clk) begin
    if (rst || init_i)
      spread_err_reg <= 1'b0;
    else if (valid_i && spread_hit)
      spread_err_reg <= 1'b1;
  end

  assign spread_err_o = spread_err_reg;
`endif

endmodule

// File: tb/tb_pmu_norm.sv
// Randomised self-checking bench for pmu_norm against a behavioural metric-bank model.
// Covers the spread flag too when PMU_SPREAD_CHK_EN is defined.
module tb_pmu_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        init_i = 1'b0;
  logic [31:0] pm_new_i = '0;
  logic [31:0] pm_o;
  logic        valid_o;
  logic [1:0]  best_state_o;
  logic [7:0]  best_pm_o;
  logic        norm_o;
  logic [15:0] norm_cnt_o;
`ifdef PMU_SPREAD_CHK_EN
  logic        spread_err_o;
`endif

  always #5 clk = ~clk;

  pmu_norm dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .init_i       (init_i),
    .pm_new_i     (pm_new_i),
    .pm_o         (pm_o),
    .valid_o      (valid_o),
    .best_state_o (best_state_o),
    .best_pm_o    (best_pm_o),
    .norm_o       (norm_o),
    .norm_cnt_o   (norm_cnt_o)
`ifdef PMU_SPREAD_CHK_EN
    ,
    .spread_err_o (spread_err_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pm[4];
  int m_bs, m_bp, m_cnt;
  bit m_valid, m_norm, m_spread;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_load();
    for (int k = 0; k < 4; k++) m_pm[k] = (k == 0) ? 0 : 255;
    m_bs = 0; m_bp = 0; m_cnt = 0;
    m_valid = 0; m_norm = 0; m_spread = 0;
  endtask

  task automatic model_step(input bit r, input bit i, input bit v, input int nv[4]);
    int mn, am, smin, smax;
    bit any;
    if (r || i) begin
      model_load();
    end else if (v) begin
      mn = nv[0]; am = 0;
      for (int k = 1; k < 4; k++) if (nv[k] < mn) begin mn = nv[k]; am = k; end
      if (mn >= 128) begin
        for (int k = 0; k < 4; k++) m_pm[k] = nv[k] - mn;
        m_bp = 0; m_norm = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        for (int k = 0; k < 4; k++) m_pm[k] = nv[k];
        m_bp = mn; m_norm = 0;
      end
      m_bs = am; m_valid = 1;
      smin = 256; smax = -1; any = 0;
      for (int k = 0; k < 4; k++) if (nv[k] != 255) begin
        any = 1;
        if (nv[k] < smin) smin = nv[k];
        if (nv[k] > smax) smax = nv[k];
      end
      if (any && (smax - smin >= 128)) m_spread = 1;
    end else begin
      m_valid = 0; m_norm = 0;
    end
  endtask

  task automatic step(input bit r, input bit i, input bit v, input int a, input int b,
                      input int c, input int d);
    int nv[4];
    logic [31:0] exp_pm;
    nv = '{a, b, c, d};
    rst = r; init_i = i; valid_i = v;
    pm_new_i = {8'(d), 8'(c), 8'(b), 8'(a)};
    @(posedge clk);
    #1;
    model_step(r, i, v, nv);
    exp_pm = {8'(m_pm[3]), 8'(m_pm[2]), 8'(m_pm[1]), 8'(m_pm[0])};
    check("pm_o", 64'(pm_o), 64'(exp_pm));
    check("best_state_o", 64'(best_state_o), 64'(m_bs));
    check("best_pm_o", 64'(best_pm_o), 64'(m_bp));
    check("valid_o", 64'(valid_o), 64'(m_valid));
    check("norm_o", 64'(norm_o), 64'(m_norm));
    check("norm_cnt_o", 64'(norm_cnt_o), 64'(m_cnt));
`ifdef PMU_SPREAD_CHK_EN
    check("spread_err_o", 64'(spread_err_o), 64'(m_spread));
`endif
    $display("txn rst=%0b init=%0b vld=%0b new=%0d,%0d,%0d,%0d -> pm=%h bs=%0d bp=%0d v=%0b n=%0b cnt=%0d",
             r, i, v, a, b, c, d, pm_o, best_state_o, best_pm_o, valid_o, norm_o, norm_cnt_o);
  endtask

  initial begin
    int lo_tab[4];
    int lo, r, i, v;
    int nv[4];
    lo_tab = '{0, 100, 128, 200};
    model_load();

    // Reset and directed scenarios
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_pm", 64'(pm_o), 64'(32'hFFFF_FF00));
    step(0, 0, 1, 10, 3, 7, 20);
    check("plain_pm", 64'(pm_o), 64'(32'h1407_030A));
    check("plain_bs", 64'(best_state_o), 64'd1);
    step(0, 0, 1, 200, 130, 140, 255);
    check("renorm_pm", 64'(pm_o), 64'(32'h7D0A_0046));
    check("renorm_cnt", 64'(norm_cnt_o), 64'd1);
    step(0, 0, 0, 9, 9, 9, 9);
    check("hold_pm", 64'(pm_o), 64'(32'h7D0A_0046));
    step(0, 0, 1, 5, 5, 9, 5);
    check("tie_bs", 64'(best_state_o), 64'd0);
    step(0, 0, 1, 127, 127, 200, 130);
    check("below_thresh_norm", 64'(norm_o), 64'd0);
    step(0, 0, 1, 128, 128, 128, 255);
    check("at_thresh_pm", 64'(pm_o), 64'(32'h7F00_0000));
    step(0, 1, 1, 1, 2, 3, 4);
    check("init_pm", 64'(pm_o), 64'(32'hFFFF_FF00));
    check("init_valid", 64'(valid_o), 64'd0);
`ifdef PMU_SPREAD_CHK_EN
    step(0, 0, 1, 0, 150, 3, 255);
    check("spread_set", 64'(spread_err_o), 64'd1);
    step(0, 0, 1, 10, 12, 14, 16);
    check("spread_sticky", 64'(spread_err_o), 64'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("spread_clear", 64'(spread_err_o), 64'd0);
`endif

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(59) == 0) ? 1 : 0;
      i = ($urandom_range(19) == 0) ? 1 : 0;
      v = ($urandom_range(3) != 0) ? 1 : 0;
      lo = lo_tab[$urandom_range(3)];
      for (int k = 0; k < 4; k++)
        nv[k] = ($urandom_range(7) == 0) ? 255 : int'($urandom_range(255, lo));
      step(r[0], i[0], v[0], nv[0], nv[1], nv[2], nv[3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
